// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    localparam int WORD_W          = 32;
    localparam int WAIT_STATES_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module mem_array
    import mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Request/response front end for mem_array with a fixed number of wait states.
// Optional misaligned-access detection: define MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        MemErr,
    output logic [1:0]  StateOut
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_WAIT    = ST_WAIT;
    localparam logic [1:0] S_RESP    = ST_RESP;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;

    logic              from_idle, commit;
    logic              c_wr, c_ok;
    logic [AW-1:0]     c_idx;
    logic [WORD_W-1:0] c_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic              mem_we;
    logic              unused_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live inputs stand in for the not-yet-loaded capture registers.
    assign from_idle = (state_q == S_IDLE);
    assign commit    = (state_d == S_RESP);
    assign c_wr      = from_idle ? Wr : wr_q;
    assign c_idx     = from_idle ? Address[AW+1:2] : idx_q;
    assign c_wdata   = from_idle ? WriteData : wdata_q;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic mis_q;
    logic c_mis;

    assign c_mis  = from_idle ? (Address[1:0] != 2'b00) : mis_q;
    assign c_ok   = ~c_mis;
    assign MemErr = (state_q == S_RESP) & mis_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mis_q <= 1'b0;
        end else if (from_idle && Req) begin
            mis_q <= (Address[1:0] != 2'b00);
        end
    end
`else
    assign c_ok   = 1'b1;
    assign MemErr = 1'b0;
`endif

    assign unused_addr = ^{Address[31:AW+2], Address[1:0]};
    assign mem_we      = commit & c_wr & c_ok;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (from_idle && Req) begin
                wr_q    <= Wr;
                idx_q   <= Address[AW+1:2];
                wdata_q <= WriteData;
            end
            if (commit && !c_wr && c_ok) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (Clk),
        .we_i   (mem_we),
        .addr_i (c_idx),
        .wdata_i(c_wdata),
        .rdata_o(arr_rdata)
    );

    assign ReqReady  = (state_q == S_IDLE);
    assign RespValid = (state_q == S_RESP);
    assign ReadData  = rdata_q;
    assign StateOut  = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder with two wait-state builds.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam int WS = 2;

    logic        Clk;
    logic        Reset;
    logic        Req, Wr;
    logic [31:0] Address, WriteData;
    logic        ReqReady, RespValid, MemErr;
    logic [31:0] ReadData;
    logic [1:0]  StateOut;

    logic        r0_req, r0_wr;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_ready, r0_valid, r0_err;
    logic [31:0] r0_rdata;
    logic [1:0]  r0_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic        err_q[$];
    logic [31:0] model [256];
    logic [31:0] last_rd;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Address(Address),
        .WriteData(WriteData), .ReqReady(ReqReady), .RespValid(RespValid),
        .ReadData(ReadData), .MemErr(MemErr), .StateOut(StateOut)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(r0_req), .Wr(r0_wr), .Address(r0_addr),
        .WriteData(r0_wdata), .ReqReady(r0_ready), .RespValid(r0_valid),
        .ReadData(r0_rdata), .MemErr(r0_err), .StateOut(r0_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // scoreboard push: derive the expected response from the reference model
    task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] idx;
        logic       mis;
        idx = addr[9:2];
        mis = ALIGN_EN && (addr[1:0] != 2'b00);
        if (wr) begin
            exp_q.push_back(last_rd);
            if (!mis) model[idx] = data;
        end else begin
            if (!mis) last_rd = model[idx];
            exp_q.push_back(last_rd);
        end
        err_q.push_back(mis);
    endtask

    // driver: present one request at the first IDLE cycle
    task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int guard;
        guard = 0;
        @(negedge Clk);
        while (!ReqReady && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        check("accept_ready", {31'd0, ReqReady}, 32'd1);
        Req = 1'b1; Wr = wr; Address = addr; WriteData = data;
        @(posedge Clk);
        #1;
        Req = 1'b0; Wr = 1'b0;
        check("state_after_accept", {30'd0, StateOut}, 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int lat;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!RespValid && lat < 20);
        check({tag, "_latency"}, lat, WS + 1);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            check({tag, "_rdata"}, ReadData, exp_q.pop_front());
            check({tag, "_memerr"}, {31'd0, MemErr}, {31'd0, err_q.pop_front()});
        end
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        push_exp(wr, addr, data);
        accept(wr, addr, data);
        wait_resp(tag);
    endtask

    initial begin
        Reset = 1'b0; Req = 1'b0; Wr = 1'b0; Address = '0; WriteData = '0;
        r0_req = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0;
        last_rd = '0;
        #12;
        check("rst_state", {30'd0, StateOut}, 32'd0);
        check("rst_valid", {31'd0, RespValid}, 32'd0);
        check("rst_ready", {31'd0, ReqReady}, 32'd1);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_memerr", {31'd0, MemErr}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // latency: write then back-to-back read
        xfer("wr_dead", 1'b1, 32'h10, 32'hDEADBEEF);
        xfer("rd_dead", 1'b0, 32'h10, 32'h0);

        // address wrap modulo 1 KiB
        xfer("wr_wrap", 1'b1, 32'h400, 32'h12345678);
        xfer("rd_wrap", 1'b0, 32'h000, 32'h0);

        xfer("wr_20", 1'b1, 32'h20, 32'h11112222);
        xfer("rd_20", 1'b0, 32'h20, 32'h0);

        // misaligned accesses
        xfer("wr_mis", 1'b1, 32'h13, 32'h55AA55AA);
        xfer("rd_10", 1'b0, 32'h10, 32'h0);
        xfer("wr_20b", 1'b1, 32'h20, 32'h11112222);
        xfer("rd_mis", 1'b0, 32'h22, 32'h0);

        // Req held high: acceptance every WS+2 cycles
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b0; Address = 32'h10;
        for (int k = 0; k < 12; k++) begin
            check("held_ready", {31'd0, ReqReady}, {31'd0, (k % 4) == 0});
            check("held_valid", {31'd0, RespValid}, {31'd0, (k % 4) == 3});
            if ((k % 4) == 3) check("held_rdata", ReadData, model[4]);
            @(negedge Clk);
        end
        Req = 1'b0;
        last_rd = model[4];

        // reset during WAIT aborts the write
        accept(1'b1, 32'h20, 32'hCAFEF00D);
        #2;
        Reset = 1'b0;
        #1;
        check("midrst_state", {30'd0, StateOut}, 32'd0);
        check("midrst_valid", {31'd0, RespValid}, 32'd0);
        check("midrst_ready", {31'd0, ReqReady}, 32'd1);
        check("midrst_rdata", ReadData, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("midrst_no_resp", {31'd0, RespValid}, 32'd0);
        end
        Reset = 1'b1;
        last_rd = '0;
        xfer("rd_after_abort", 1'b0, 32'h20, 32'h0);

        // randomized write/read-back pairs, high address bits random
        for (int i = 0; i < 6; i++) begin
            logic [31:0] addr, data;
            addr = ($urandom_range(0, 7) << 10) | ($urandom_range(0, 255) << 2);
            data = $urandom;
            xfer("rnd_wr", 1'b1, addr, data);
            xfer("rnd_rd", 1'b0, {22'd0, addr[9:0]}, 32'h0);
        end

        // zero-wait-state instance
        @(negedge Clk);
        r0_req = 1'b1; r0_wr = 1'b1; r0_addr = 32'h10; r0_wdata = 32'hA5A5A5A5;
        @(negedge Clk);
        check("ws0_wr_valid", {31'd0, r0_valid}, 32'd1);
        check("ws0_wr_ready", {31'd0, r0_ready}, 32'd0);
        check("ws0_wr_state", {30'd0, r0_state}, 32'd2);
        check("ws0_wr_rdata", r0_rdata, 32'd0);
        check("ws0_wr_memerr", {31'd0, r0_err}, 32'd0);
        r0_wr = 1'b0;
        @(negedge Clk);
        for (int k = 0; k < 6; k++) begin
            check("ws0_ready", {31'd0, r0_ready}, {31'd0, (k % 2) == 0});
            check("ws0_valid", {31'd0, r0_valid}, {31'd0, (k % 2) == 1});
            if ((k % 2) == 1) check("ws0_rdata", r0_rdata, 32'hA5A5A5A5);
            @(negedge Clk);
        end
        r0_req = 1'b0;

        repeat (3) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
